// File: rtl/gpio_bank_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bank_pkg
// Shared definitions for the GPIO bank: word register indices and the
// per-pin edge-select encoding. Also consumed by firmware header generation,
// so names and values here are part of the software-visible contract.
// -----------------------------------------------------------------------------
package gpio_bank_pkg;

   // Word register indices on the IO page
   typedef enum logic [2:0] {
      GPIO_REG_OUT        = 3'd0,
      GPIO_REG_DIR        = 3'd1,
      GPIO_REG_IN         = 3'd2,
      GPIO_REG_IRQ_EN     = 3'd3,
      GPIO_REG_IRQ_EDGE   = 3'd4,
      GPIO_REG_IRQ_STATUS = 3'd5,
      GPIO_REG_OUT_SET    = 3'd6,
      GPIO_REG_OUT_CLR    = 3'd7
   } gpio_reg_e;

   // IRQ_EDGE bit encoding
   localparam logic GPIO_EDGE_RISE = 1'b0;
   localparam logic GPIO_EDGE_FALL = 1'b1;

   // Bus data width of the IO page
   localparam int GPIO_BUS_W = 32;

endpackage : gpio_bank_pkg

// File: rtl/gpio_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
// WIDTH-wide multi-stage synchroniser for asynchronous pad inputs, plus the
// previous-value flop that feeds rising/falling edge detection.
// Build option: GPIO_BANK_IRQ_EN -- when defined, the previous-value flop and
// the o_rise / o_fall outputs exist; otherwise only o_sync is produced.
//
// Ports:
//   i_clk     clock
//   i_resetn  asynchronous active-low reset
//   i_pad     asynchronous pad inputs
//   o_sync    synchronised pad value (last synchroniser stage)
//   o_rise    synchronised value went 0 -> 1 (GPIO_BANK_IRQ_EN only)
//   o_fall    synchronised value went 1 -> 0 (GPIO_BANK_IRQ_EN only)
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic [WIDTH-1:0] i_pad,
`ifdef GPIO_BANK_IRQ_EN
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
`endif
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_stage [SYNC_STAGES];

   // Synchroniser shift chain: stage 0 samples the pad, later stages resolve metastability
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_stage[k] <= {WIDTH{1'b0}};
         end
      end else begin
         r_stage[0] <= i_pad;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign o_sync = r_stage[SYNC_STAGES-1];

`ifdef GPIO_BANK_IRQ_EN
   logic [WIDTH-1:0] r_prev;

   // Previous synchronised value; resets to 0 so a pin high through reset shows a rising edge
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_prev <= {WIDTH{1'b0}};
      end else begin
         r_prev <= o_sync;
      end
   end

   assign o_rise = o_sync & ~r_prev;
   assign o_fall = ~o_sync & r_prev;
`endif

endmodule : gpio_sync_edge

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Memory-mapped GPIO bank: per-pin direction, atomic set/clear of the output
// register, synchronised input read-back and per-pin edge-capture interrupts
// with write-1-to-clear status.
// Build option: GPIO_BANK_IRQ_EN -- when defined, IRQ_EN / IRQ_EDGE /
// IRQ_STATUS and the edge logic are built; when undefined, indices 3..5 read
// 0 and ignore writes, and irq is tied low.
//
// Ports:
//   clk        sole clock
//   resetn     asynchronous active-low reset
//   sel        block select from the SoC address decode
//   addr       word register index (see gpio_bank_pkg)
//   wr_enable  write strobe, qualified by sel
//   wdata      write data; bits at and above WIDTH ignored
//   rdata      combinational read data, zero above WIDTH, 0 when sel is low
//   gpio_in    asynchronous pad inputs
//   gpio_out   output data (OUT register)
//   gpio_oe    output enable, 1 = drive (DIR register)
//   irq        level interrupt, OR of enabled status bits
// -----------------------------------------------------------------------------
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  sel,
   input  logic [2:0]            addr,
   input  logic                  wr_enable,
   input  logic [GPIO_BUS_W-1:0] wdata,
   output logic [GPIO_BUS_W-1:0] rdata,
   input  logic [WIDTH-1:0]      gpio_in,
   output logic [WIDTH-1:0]      gpio_out,
   output logic [WIDTH-1:0]      gpio_oe,
   output logic                  irq
);

   logic                  w_we;
   logic [WIDTH-1:0]      w_wdata;
   logic [WIDTH-1:0]      w_sync;
   logic [WIDTH-1:0]      r_out;
   logic [WIDTH-1:0]      r_dir;
   logic [WIDTH-1:0]      w_out_nxt;
   logic [WIDTH-1:0]      w_dir_nxt;
   logic [WIDTH-1:0]      w_rd_field;
   logic [GPIO_BUS_W-1:0] w_rdata;

   assign w_we    = sel & wr_enable;
   assign w_wdata = wdata[WIDTH-1:0];

`ifdef GPIO_BANK_IRQ_EN
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_w1c;
   logic [WIDTH-1:0] r_irq_en;
   logic [WIDTH-1:0] r_irq_edge;
   logic [WIDTH-1:0] r_irq_status;
   logic [WIDTH-1:0] w_irq_en_nxt;
   logic [WIDTH-1:0] w_irq_edge_nxt;
   logic [WIDTH-1:0] w_irq_status_nxt;

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_pad    (gpio_in),
      .o_rise   (w_rise),
      .o_fall   (w_fall),
      .o_sync   (w_sync)
   );
`else
   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .i_clk    (clk),
      .i_resetn (resetn),
      .i_pad    (gpio_in),
      .o_sync   (w_sync)
   );
`endif

   // Next-state for OUT and DIR, including the atomic set/clear aliases
   always_comb begin
      w_out_nxt = r_out;
      w_dir_nxt = r_dir;
      if (w_we) begin
         case (addr)
            GPIO_REG_OUT:     w_out_nxt = w_wdata;
            GPIO_REG_DIR:     w_dir_nxt = w_wdata;
            GPIO_REG_OUT_SET: w_out_nxt = r_out | w_wdata;
            GPIO_REG_OUT_CLR: w_out_nxt = r_out & ~w_wdata;
            default: begin
               w_out_nxt = r_out;
               w_dir_nxt = r_dir;
            end
         endcase
      end else begin
         w_out_nxt = r_out;
         w_dir_nxt = r_dir;
      end
   end

   // OUT and DIR registers; they drive the pins directly
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out <= {WIDTH{1'b0}};
         r_dir <= {WIDTH{1'b0}};
      end else begin
         r_out <= w_out_nxt;
         r_dir <= w_dir_nxt;
      end
   end

   assign gpio_out = r_out;
   assign gpio_oe  = r_dir;

`ifdef GPIO_BANK_IRQ_EN
   // Per-pin edge selection between rising and falling detection
   always_comb begin
      w_edge = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (r_irq_edge[i] == GPIO_EDGE_FALL) begin
            w_edge[i] = w_fall[i];
         end else begin
            w_edge[i] = w_rise[i];
         end
      end
   end

   // Next-state for IRQ configuration and status; a same-cycle edge beats the W1C
   always_comb begin
      w_irq_en_nxt   = r_irq_en;
      w_irq_edge_nxt = r_irq_edge;
      w_w1c          = {WIDTH{1'b0}};
      if (w_we) begin
         case (addr)
            GPIO_REG_IRQ_EN:     w_irq_en_nxt   = w_wdata;
            GPIO_REG_IRQ_EDGE:   w_irq_edge_nxt = w_wdata;
            GPIO_REG_IRQ_STATUS: w_w1c          = w_wdata;
            default: begin
               w_irq_en_nxt   = r_irq_en;
               w_irq_edge_nxt = r_irq_edge;
               w_w1c          = {WIDTH{1'b0}};
            end
         endcase
      end else begin
         w_w1c = {WIDTH{1'b0}};
      end
      w_irq_status_nxt = (r_irq_status & ~w_w1c) | w_edge;
   end

   // IRQ configuration and sticky status registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_irq_en     <= {WIDTH{1'b0}};
         r_irq_edge   <= {WIDTH{1'b0}};
         r_irq_status <= {WIDTH{1'b0}};
      end else begin
         r_irq_en     <= w_irq_en_nxt;
         r_irq_edge   <= w_irq_edge_nxt;
         r_irq_status <= w_irq_status_nxt;
      end
   end

   // Pure flop-to-output reduction, no combinational path from the bus
   assign irq = |(r_irq_status & r_irq_en);
`else
   assign irq = 1'b0;
`endif

   // Read mux; write-only and absent registers return 0
   always_comb begin
      w_rd_field = {WIDTH{1'b0}};
      if (sel) begin
         case (addr)
            GPIO_REG_OUT:        w_rd_field = r_out;
            GPIO_REG_DIR:        w_rd_field = r_dir;
            GPIO_REG_IN:         w_rd_field = w_sync;
`ifdef GPIO_BANK_IRQ_EN
            GPIO_REG_IRQ_EN:     w_rd_field = r_irq_en;
            GPIO_REG_IRQ_EDGE:   w_rd_field = r_irq_edge;
            GPIO_REG_IRQ_STATUS: w_rd_field = r_irq_status;
`endif
            default:             w_rd_field = {WIDTH{1'b0}};
         endcase
      end else begin
         w_rd_field = {WIDTH{1'b0}};
      end
      w_rdata = {GPIO_BUS_W{1'b0}};
      w_rdata[WIDTH-1:0] = w_rd_field;
   end

   assign rdata = w_rdata;

endmodule : gpio_bank

// File: tb/tb_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_bank
// Self-checking bench for gpio_bank. A register-level model tracks the
// software-visible state and the pad history; a negedge process compares
// every output against it each cycle, and directed sequences add literal
// expectations. A second instance with WIDTH = 5 covers truncation.
// -----------------------------------------------------------------------------
module tb_gpio_bank;

   localparam int SYNC = 2;

   logic        clk;
   logic        resetn;
   logic        sel;
   logic [2:0]  addr;
   logic        wr_enable;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oe;
   logic        irq;

   logic [31:0] rdata5;
   logic [4:0]  gpio_in5;
   logic [4:0]  gpio_out5;
   logic [4:0]  gpio_oe5;
   logic        irq5;

   int n_pass  = 0;
   int n_total = 0;

   gpio_bank #(.WIDTH(32), .SYNC_STAGES(SYNC)) u_dut (
      .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wr_enable(wr_enable),
      .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .gpio_oe(gpio_oe), .irq(irq)
   );

   gpio_bank #(.WIDTH(5), .SYNC_STAGES(SYNC)) u_dut5 (
      .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wr_enable(wr_enable),
      .wdata(wdata), .rdata(rdata5), .gpio_in(gpio_in5), .gpio_out(gpio_out5),
      .gpio_oe(gpio_oe5), .irq(irq5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_out, m_dir, m_en, m_edge, m_status;
   logic [31:0] m_hist [0:SYNC];   // m_hist[k] = pad as sampled k+1 edges ago

   function automatic logic [31:0] m_in();
      return m_hist[SYNC-1];
   endfunction

   function automatic logic [31:0] m_edges();
      logic [31:0] now_v, was_v;
      now_v = m_hist[SYNC-1];
      was_v = m_hist[SYNC];
      return ((now_v & ~was_v) & ~m_edge) | ((~now_v & was_v) & m_edge);
   endfunction

   function automatic logic m_irq();
`ifdef GPIO_BANK_IRQ_EN
      return |(m_status & m_en);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_out;
         3'd1:    return m_dir;
         3'd2:    return m_in();
`ifdef GPIO_BANK_IRQ_EN
         3'd3:    return m_en;
         3'd4:    return m_edge;
         3'd5:    return m_status;
`endif
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_out <= 32'd0; m_dir <= 32'd0; m_en <= 32'd0; m_edge <= 32'd0; m_status <= 32'd0;
         for (int k = 0; k <= SYNC; k++) m_hist[k] <= 32'd0;
      end else begin
         m_hist[0] <= gpio_in;
         for (int k = 1; k <= SYNC; k++) m_hist[k] <= m_hist[k-1];
         if (sel && wr_enable) begin
            case (addr)
               3'd0: m_out  <= wdata;
               3'd1: m_dir  <= wdata;
               3'd3: m_en   <= wdata;
               3'd4: m_edge <= wdata;
               3'd6: m_out  <= m_out | wdata;
               3'd7: m_out  <= m_out & ~wdata;
               default: ;
            endcase
         end
         if (sel && wr_enable && addr == 3'd5)
            m_status <= (m_status & ~wdata) | m_edges();
         else
            m_status <= m_status | m_edges();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("gpio_out", gpio_out, m_out);
      chk("gpio_oe", gpio_oe, m_dir);
      chk("irq", {31'd0, irq}, {31'd0, m_irq()});
      chk("rdata", rdata, sel ? m_read(addr) : 32'd0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      sel = 1'b1; wr_enable = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      sel = 1'b0; wr_enable = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      sel = 1'b1; wr_enable = 1'b0; addr = a;
      #1;
      chk(name, rdata, exp);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      resetn = 1'b0; sel = 1'b0; addr = 3'd0; wr_enable = 1'b0; wdata = 32'd0;
      gpio_in = 32'd0; gpio_in5 = 5'd0;
      tick(3);
      resetn = 1'b1;
      chk("rst_gpio_out", gpio_out, 32'd0);
      chk("rst_gpio_oe", gpio_oe, 32'd0);
      chk("rst_rdata_idle", rdata, 32'd0);

      // Asynchronous reset in the middle of a write
      wr(3'd0, 32'h0000_00FF);
      wr(3'd1, 32'h0000_00FF);
      chk("pre_rst_out", gpio_out, 32'h0000_00FF);
      sel = 1'b1; wr_enable = 1'b1; addr = 3'd0; wdata = 32'h0000_1234;
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_out", gpio_out, 32'd0);
      chk("async_rst_oe", gpio_oe, 32'd0);
      chk("async_rst_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      sel = 1'b0; wr_enable = 1'b0;
      resetn = 1'b1;
      for (int a = 0; a < 8; a++) rd_chk("rst_reg_zero", 3'(a), 32'd0);
      sel = 1'b0;

      // Set / clear aliases
      wr(3'd0, 32'h0000_00F0);
      chk("out_write", gpio_out, 32'h0000_00F0);
      wr(3'd6, 32'h0000_000F);
      chk("out_set", gpio_out, 32'h0000_00FF);
      wr(3'd7, 32'h0000_0030);
      chk("out_clr", gpio_out, 32'h0000_00CF);
      rd_chk("out_read", 3'd0, 32'h0000_00CF);
      wr(3'd1, 32'h0000_0000);
      rd_chk("dir_read", 3'd1, 32'd0);

      // Input synchroniser latency
      gpio_in[5] = 1'b1;
      rd_chk("in_edge0", 3'd2, 32'd0);
      tick(1);
      chk("in_edge1", rdata, 32'd0);
      tick(1);
      chk("in_edge2", rdata, 32'h0000_0020);
      tick(3);

`ifdef GPIO_BANK_IRQ_EN
      // Rising-edge interrupt
      wr(3'd5, 32'hFFFF_FFFF);
      rd_chk("status_cleared", 3'd5, 32'd0);
      wr(3'd3, 32'h0000_0001);
      gpio_in[0] = 1'b1;
      tick(1);
      gpio_in[0] = 1'b0;
      chk("rise_irq_e1", {31'd0, irq}, 32'd0);
      tick(1);
      chk("rise_irq_e2", {31'd0, irq}, 32'd0);
      tick(1);
      chk("rise_irq_e3", {31'd0, irq}, 32'd1);
      rd_chk("rise_status", 3'd5, 32'h0000_0001);
      wr(3'd5, 32'h0000_0001);
      chk("w1c_irq_low", {31'd0, irq}, 32'd0);

      // Falling edge, then collision with W1C
      wr(3'd4, 32'h0000_0004);
      wr(3'd3, 32'h0000_0005);
      gpio_in[2] = 1'b1;
      tick(4);
      rd_chk("fall_no_rise", 3'd5, 32'd0);
      gpio_in[2] = 1'b0;
      tick(3);
      chk("fall_irq", {31'd0, irq}, 32'd1);
      gpio_in[2] = 1'b1;
      tick(4);
      gpio_in[2] = 1'b0;
      tick(2);
      wr(3'd5, 32'h0000_0004);
      chk("collide_irq", {31'd0, irq}, 32'd1);
      rd_chk("collide_status", 3'd5, 32'h0000_0004);
      wr(3'd5, 32'h0000_0004);
      chk("final_w1c_irq", {31'd0, irq}, 32'd0);
`else
      // No IRQ logic: edges never raise irq, indices 3..5 read 0
      wr(3'd3, 32'hFFFF_FFFF);
      wr(3'd4, 32'hFFFF_FFFF);
      gpio_in[0] = 1'b1;
      tick(5);
      chk("noirq_irq", {31'd0, irq}, 32'd0);
      rd_chk("noirq_en", 3'd3, 32'd0);
      rd_chk("noirq_edge", 3'd4, 32'd0);
      rd_chk("noirq_status", 3'd5, 32'd0);
      rd_chk("noirq_in", 3'd2, 32'h0000_0021);
`endif

      // Width truncation and write-only reads
      wr(3'd0, 32'hFFFF_FFFF);
      chk("w5_gpio_out", {27'd0, gpio_out5}, 32'h0000_001F);
      rd_chk("w32_out", 3'd0, 32'hFFFF_FFFF);
      chk("w5_out_read", rdata5, 32'h0000_001F);
      rd_chk("set_reads_zero", 3'd6, 32'd0);
      rd_chk("clr_reads_zero", 3'd7, 32'd0);
      wr(3'd2, 32'h0000_0000);
      rd_chk("in_write_ignored", 3'd2, m_in());
      sel = 1'b0;
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_gpio_bank
